// File: rtl/rs_alu_pkg.sv
// -----------------------------------------------------------------------------
// rs_alu_pkg
// Shared definitions for the ALU reservation station slice:
//   XLEN / PRF_LEN / ROB_LEN  datapath, physical-register-tag and ROB index widths
//   ALU_FUNC                  ALU operation encoding
//   RS_FU_PACKET              op handed from the station to the ALU
//   RS_ALU_ENTRY              one reservation-station slot
//   tag_hit()                 CDB tag-match helper used for wakeup and capture
// -----------------------------------------------------------------------------
package rs_alu_pkg;

  localparam int XLEN    = 32;
  localparam int PRF_LEN = 6;
  localparam int ROB_LEN = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } ALU_FUNC;

  typedef struct packed {
    logic [XLEN-1:0]    opa_value;
    logic [XLEN-1:0]    opb_value;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_index;
    ALU_FUNC            alu_func;
  } RS_FU_PACKET;

  // opa_value/opb_value hold the operand when ready, otherwise the
  // producing preg tag in the low PRF_LEN bits.
  typedef struct packed {
    logic               valid;
    logic               opa_ready;
    logic               opb_ready;
    logic [XLEN-1:0]    opa_value;
    logic [XLEN-1:0]    opb_value;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_index;
    ALU_FUNC            alu_func;
  } RS_ALU_ENTRY;

  // True when a still-waiting operand is being produced on the CDB now.
  function automatic logic tag_hit(input logic               cdb_valid,
                                   input logic [PRF_LEN-1:0] cdb_tag,
                                   input logic               opnd_ready,
                                   input logic [PRF_LEN-1:0] opnd_tag);
    return cdb_valid && !opnd_ready && (opnd_tag == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_alu_if.sv
// -----------------------------------------------------------------------------
// rs_alu_if
// Bundles every non-clock signal of the ALU reservation station.
//   dispatch_*   new op from rename/ROB allocation
//   cdb_*        common data bus broadcast (wakeup)
//   fu_ready     ALU can take an op next cycle
//   squash       pipeline flush
//   rs_fu_packet / alu_enable   issued op towards the ALU (registered)
//   rs_full / rs_free_count     occupancy back to dispatch
// Modports: master = dispatch/CDB/ALU side, slave = reservation station.
// -----------------------------------------------------------------------------
interface rs_alu_if
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = 8
) ();

  localparam int RS_LEN = $clog2(RS_SIZE);

  logic               squash;
  logic               dispatch_enable;
  ALU_FUNC            dispatch_alu_func;
  logic               dispatch_opa_ready;
  logic [XLEN-1:0]    dispatch_opa_value;
  logic               dispatch_opb_ready;
  logic [XLEN-1:0]    dispatch_opb_value;
  logic [PRF_LEN-1:0] dispatch_dest_preg_idx;
  logic [ROB_LEN-1:0] dispatch_rob_index;
  logic               cdb_valid;
  logic [PRF_LEN-1:0] cdb_preg_idx;
  logic [XLEN-1:0]    cdb_value;
  logic               fu_ready;
  RS_FU_PACKET        rs_fu_packet;
  logic               alu_enable;
  logic               rs_full;
  logic [RS_LEN:0]    rs_free_count;

  modport master (
    output squash, dispatch_enable, dispatch_alu_func,
           dispatch_opa_ready, dispatch_opa_value,
           dispatch_opb_ready, dispatch_opb_value,
           dispatch_dest_preg_idx, dispatch_rob_index,
           cdb_valid, cdb_preg_idx, cdb_value, fu_ready,
    input  rs_fu_packet, alu_enable, rs_full, rs_free_count
  );

  modport slave (
    input  squash, dispatch_enable, dispatch_alu_func,
           dispatch_opa_ready, dispatch_opa_value,
           dispatch_opb_ready, dispatch_opb_value,
           dispatch_dest_preg_idx, dispatch_rob_index,
           cdb_valid, cdb_preg_idx, cdb_value, fu_ready,
    output rs_fu_packet, alu_enable, rs_full, rs_free_count
  );

endinterface

// File: rtl/rs_alu_psel.sv
// -----------------------------------------------------------------------------
// rs_psel
// Lowest-index fixed-priority selector.
//   req   [WIDTH-1:0]  request vector
//   gnt   [WIDTH-1:0]  one-hot grant of the lowest set request (0 if none)
//   found              any request set
// -----------------------------------------------------------------------------
module rs_psel #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic             found
);

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// -----------------------------------------------------------------------------
// rs_alu
// Reservation station for the single-cycle ALU. Holds dispatched ops until
// both operands are ready (snooping the CDB), then issues the lowest-index
// ready op to the ALU, one per cycle.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high; drops all entries and the issue output
//   rs     rs_alu_if.slave (dispatch, CDB, fu_ready, squash, issue, occupancy)
// Parameters: RS_SIZE entries (power of 2, >= 2), RS_LEN index width.
// Build option: define RS_CDB_BYPASS_EN to let an existing entry whose last
// operand arrives on the CDB issue in that same cycle, forwarding cdb_value.
// -----------------------------------------------------------------------------
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int RS_LEN  = $clog2(RS_SIZE)
) (
  input  logic    clock,
  input  logic    reset,
  rs_alu_if.slave rs
);

  localparam logic [RS_LEN:0] CNT_ONE = {{RS_LEN{1'b0}}, 1'b1};

  RS_ALU_ENTRY rs_q [RS_SIZE];
  RS_ALU_ENTRY rs_n [RS_SIZE];

  logic [RS_SIZE-1:0] valid_vec;
  logic [RS_SIZE-1:0] free_req;
  logic [RS_SIZE-1:0] free_gnt;
  logic               free_found;
  logic [RS_SIZE-1:0] rdy_req;
  logic [RS_SIZE-1:0] rdy_gnt;
  logic               rdy_found;
  logic [RS_SIZE-1:0] hit_a;
  logic [RS_SIZE-1:0] hit_b;
  logic [RS_LEN:0]    free_cnt;
  logic               dispatch_go;
  logic               issue_go;
  logic               disp_hit_a;
  logic               disp_hit_b;
  RS_ALU_ENTRY        disp_entry;
  RS_FU_PACKET        issue_pkt;

  // Occupancy: derived from registered valid bits only, so a slot freed by
  // this cycle's issue is not offered to this cycle's dispatch.
  always_comb begin
    free_cnt = RS_LEN'(0) + (RS_LEN+1)'(RS_SIZE);
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = rs_q[i].valid;
      if (rs_q[i].valid) free_cnt = free_cnt - CNT_ONE;
    end
  end

  assign free_req         = ~valid_vec;
  assign rs.rs_full       = ~free_found;
  assign rs.rs_free_count = free_cnt;

  rs_psel #(.WIDTH(RS_SIZE)) u_free_sel (
    .req   (free_req),
    .gnt   (free_gnt),
    .found (free_found)
  );

  // CDB snoop against resident entries.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      hit_a[i] = rs_q[i].valid &&
                 tag_hit(rs.cdb_valid, rs.cdb_preg_idx, rs_q[i].opa_ready,
                         rs_q[i].opa_value[PRF_LEN-1:0]);
      hit_b[i] = rs_q[i].valid &&
                 tag_hit(rs.cdb_valid, rs.cdb_preg_idx, rs_q[i].opb_ready,
                         rs_q[i].opb_value[PRF_LEN-1:0]);
`ifdef RS_CDB_BYPASS_EN
      rdy_req[i] = rs_q[i].valid &&
                   (rs_q[i].opa_ready || hit_a[i]) &&
                   (rs_q[i].opb_ready || hit_b[i]);
`else
      rdy_req[i] = rs_q[i].valid && rs_q[i].opa_ready && rs_q[i].opb_ready;
`endif
    end
  end

  rs_psel #(.WIDTH(RS_SIZE)) u_rdy_sel (
    .req   (rdy_req),
    .gnt   (rdy_gnt),
    .found (rdy_found)
  );

  assign dispatch_go = rs.dispatch_enable && free_found && !rs.squash;
  assign issue_go    = rs.fu_ready && rdy_found && !rs.squash;

  // Issue mux: a forwarded operand takes cdb_value; this only matters when
  // the bypass build makes a just-woken entry selectable.
  always_comb begin
    issue_pkt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (rdy_gnt[i]) begin
        issue_pkt.opa_value     = hit_a[i] ? rs.cdb_value : rs_q[i].opa_value;
        issue_pkt.opb_value     = hit_b[i] ? rs.cdb_value : rs_q[i].opb_value;
        issue_pkt.dest_preg_idx = rs_q[i].dest_preg_idx;
        issue_pkt.rob_index     = rs_q[i].rob_index;
        issue_pkt.alu_func      = rs_q[i].alu_func;
      end
    end
  end

  // New entry: operands whose producer is on the CDB right now are captured
  // ready, otherwise the wakeup would be missed forever.
  always_comb begin
    disp_hit_a = tag_hit(rs.cdb_valid, rs.cdb_preg_idx, rs.dispatch_opa_ready,
                         rs.dispatch_opa_value[PRF_LEN-1:0]);
    disp_hit_b = tag_hit(rs.cdb_valid, rs.cdb_preg_idx, rs.dispatch_opb_ready,
                         rs.dispatch_opb_value[PRF_LEN-1:0]);
    disp_entry.valid         = 1'b1;
    disp_entry.opa_ready     = rs.dispatch_opa_ready || disp_hit_a;
    disp_entry.opb_ready     = rs.dispatch_opb_ready || disp_hit_b;
    disp_entry.opa_value     = disp_hit_a ? rs.cdb_value : rs.dispatch_opa_value;
    disp_entry.opb_value     = disp_hit_b ? rs.cdb_value : rs.dispatch_opb_value;
    disp_entry.dest_preg_idx = rs.dispatch_dest_preg_idx;
    disp_entry.rob_index     = rs.dispatch_rob_index;
    disp_entry.alu_func      = rs.dispatch_alu_func;
  end

  // Next state per entry: wakeup, issue-clear, dispatch-write, squash.
  // Dispatch targets a slot that is free in the registered state, so it can
  // never collide with the issuing slot.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      rs_n[i] = rs_q[i];
      if (hit_a[i]) begin
        rs_n[i].opa_ready = 1'b1;
        rs_n[i].opa_value = rs.cdb_value;
      end
      if (hit_b[i]) begin
        rs_n[i].opb_ready = 1'b1;
        rs_n[i].opb_value = rs.cdb_value;
      end
      if (issue_go && rdy_gnt[i]) rs_n[i].valid = 1'b0;
      if (dispatch_go && free_gnt[i]) rs_n[i] = disp_entry;
      if (rs.squash) rs_n[i].valid = 1'b0;
    end
  end

  // ---- register boundary: entry state and issue packet ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RS_SIZE; i++) rs_q[i].valid <= 1'b0;
      rs.alu_enable   <= 1'b0;
      rs.rs_fu_packet <= '0;
    end else begin
      rs_q          <= rs_n;
      rs.alu_enable <= issue_go;
      if (issue_go) rs.rs_fu_packet <= issue_pkt;
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// -----------------------------------------------------------------------------
// tb_rs_alu
// Directed bench for rs_alu (RS_SIZE = 8): reset state, ready dispatch/issue,
// CDB wakeup, dispatch-time CDB capture, full station, fu_ready stall with
// priority order, squash and asynchronous reset during issue.
// -----------------------------------------------------------------------------
module tb_rs_alu;
  import rs_alu_pkg::*;

`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock;
  logic reset;
  int   total;
  int   bad;

  rs_alu_if #(.RS_SIZE(8)) bus ();

  rs_alu #(.RS_SIZE(8)) dut (
    .clock (clock),
    .reset (reset),
    .rs    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.squash          = 1'b0;
    bus.dispatch_enable = 1'b0;
    bus.cdb_valid       = 1'b0;
  endtask

  task automatic disp(input ALU_FUNC f,
                      input logic ar, input logic [XLEN-1:0] av,
                      input logic br, input logic [XLEN-1:0] bv,
                      input logic [PRF_LEN-1:0] d, input logic [ROB_LEN-1:0] r);
    bus.dispatch_enable        = 1'b1;
    bus.dispatch_alu_func      = f;
    bus.dispatch_opa_ready     = ar;
    bus.dispatch_opa_value     = av;
    bus.dispatch_opb_ready     = br;
    bus.dispatch_opb_value     = bv;
    bus.dispatch_dest_preg_idx = d;
    bus.dispatch_rob_index     = r;
  endtask

  task automatic cdb(input logic [PRF_LEN-1:0] t, input logic [XLEN-1:0] v);
    bus.cdb_valid    = 1'b1;
    bus.cdb_preg_idx = t;
    bus.cdb_value    = v;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    disp(ALU_ADD, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 5'd0);
    bus.dispatch_enable = 1'b0;
    cdb(6'd0, 32'h0);
    bus.cdb_valid = 1'b0;
    bus.fu_ready  = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_en",   32'(bus.alu_enable), 32'd0);
    chk("rst_opa",  bus.rs_fu_packet.opa_value, 32'd0);
    chk("rst_dest", 32'(bus.rs_fu_packet.dest_preg_idx), 32'd0);
    chk("rst_full", 32'(bus.rs_full), 32'd0);
    chk("rst_free", 32'(bus.rs_free_count), 32'd8);
    reset = 1'b0;

    // Ready ADD: cannot issue on its dispatch edge, issues on the next
    bus.fu_ready = 1'b1;
    disp(ALU_ADD, 1'b1, 32'd5, 1'b1, 32'd7, 6'd12, 5'd3);
    step();
    idle();
    chk("add_en_disp", 32'(bus.alu_enable), 32'd0);
    chk("add_free_disp", 32'(bus.rs_free_count), 32'd7);
    step();
    chk("add_en",   32'(bus.alu_enable), 32'd1);
    chk("add_opa",  bus.rs_fu_packet.opa_value, 32'd5);
    chk("add_opb",  bus.rs_fu_packet.opb_value, 32'd7);
    chk("add_dest", 32'(bus.rs_fu_packet.dest_preg_idx), 32'd12);
    chk("add_rob",  32'(bus.rs_fu_packet.rob_index), 32'd3);
    chk("add_func", 32'(bus.rs_fu_packet.alu_func), 32'(ALU_ADD));
    chk("add_free", 32'(bus.rs_free_count), 32'd8);
    step();
    chk("add_en_off", 32'(bus.alu_enable), 32'd0);

    // SUB waiting on preg 9, woken by the CDB
    disp(ALU_SUB, 1'b0, 32'd9, 1'b1, 32'd1, 6'd13, 5'd4);
    step();
    idle();
    step();
    chk("sub_wait0", 32'(bus.alu_enable), 32'd0);
    step();
    chk("sub_wait1", 32'(bus.alu_enable), 32'd0);
    cdb(6'd9, 32'h20);
    step();
    idle();
    chk("sub_en_wake", 32'(bus.alu_enable), 32'(BYP));
    if (!BYP) step();
    chk("sub_en",   32'(bus.alu_enable), 32'd1);
    chk("sub_opa",  bus.rs_fu_packet.opa_value, 32'h20);
    chk("sub_opb",  bus.rs_fu_packet.opb_value, 32'd1);
    chk("sub_dest", 32'(bus.rs_fu_packet.dest_preg_idx), 32'd13);
    chk("sub_func", 32'(bus.rs_fu_packet.alu_func), 32'(ALU_SUB));
    step();
    chk("sub_en_off", 32'(bus.alu_enable), 32'd0);
    chk("sub_free", 32'(bus.rs_free_count), 32'd8);

    // Dispatch while the CDB carries the awaited tag
    disp(ALU_AND, 1'b0, 32'd4, 1'b1, 32'd2, 6'd14, 5'd5);
    cdb(6'd4, 32'hABCD);
    step();
    idle();
    chk("cap_en_disp", 32'(bus.alu_enable), 32'd0);
    step();
    chk("cap_en",   32'(bus.alu_enable), 32'd1);
    chk("cap_opa",  bus.rs_fu_packet.opa_value, 32'hABCD);
    chk("cap_opb",  bus.rs_fu_packet.opb_value, 32'd2);
    chk("cap_dest", 32'(bus.rs_fu_packet.dest_preg_idx), 32'd14);
    step();
    chk("cap_free", 32'(bus.rs_free_count), 32'd8);

    // Fill the station with not-ready ops (tags 20..27, dest 40..47)
    for (int i = 0; i < 8; i++) begin
      disp(ALU_OR, 1'b0, 32'(20 + i), 1'b1, 32'd0, PRF_LEN'(40 + i), ROB_LEN'(i));
      step();
    end
    idle();
    chk("full_flag", 32'(bus.rs_full), 32'd1);
    chk("full_free", 32'(bus.rs_free_count), 32'd0);
    disp(ALU_XOR, 1'b1, 32'd1, 1'b1, 32'd1, 6'd60, 5'd9);
    step();
    idle();
    chk("full_ign_free", 32'(bus.rs_free_count), 32'd0);
    step();
    chk("full_ign_en", 32'(bus.alu_enable), 32'd0);
    cdb(6'd23, 32'h77);
    step();
    idle();
    chk("full_wake_full", 32'(bus.rs_full), 32'(!BYP));
    if (!BYP) step();
    chk("full_iss_en",   32'(bus.alu_enable), 32'd1);
    chk("full_iss_opa",  bus.rs_fu_packet.opa_value, 32'h77);
    chk("full_iss_dest", 32'(bus.rs_fu_packet.dest_preg_idx), 32'd43);
    chk("full_iss_rob",  32'(bus.rs_fu_packet.rob_index), 32'd3);
    chk("full_after",    32'(bus.rs_full), 32'd0);
    chk("full_free1",    32'(bus.rs_free_count), 32'd1);

    // Squash: clear leftovers, then squash 5 entries with one ready
    bus.squash = 1'b1;
    step();
    idle();
    chk("sq_clear_free", 32'(bus.rs_free_count), 32'd8);
    bus.fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(ALU_ADD, 1'b0, 32'(30 + i), 1'b1, 32'd0, PRF_LEN'(20 + i), ROB_LEN'(i));
      step();
    end
    disp(ALU_ADD, 1'b1, 32'd3, 1'b1, 32'd4, 6'd25, 5'd7);
    step();
    idle();
    chk("sq_free5", 32'(bus.rs_free_count), 32'd3);
    bus.fu_ready = 1'b1;
    bus.squash   = 1'b1;
    step();
    idle();
    chk("sq_en",   32'(bus.alu_enable), 32'd0);
    chk("sq_free", 32'(bus.rs_free_count), 32'd8);
    step();
    chk("sq_en2",  32'(bus.alu_enable), 32'd0);

    // Stall with three ready ops, then drain in index order
    bus.fu_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      disp(ALU_SLT, 1'b1, 32'(100 + i), 1'b1, 32'd0, PRF_LEN'(i), ROB_LEN'(i));
      step();
    end
    idle();
    step();
    chk("stall_en0", 32'(bus.alu_enable), 32'd0);
    step();
    chk("stall_en1", 32'(bus.alu_enable), 32'd0);
    chk("stall_free", 32'(bus.rs_free_count), 32'd5);
    bus.fu_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("prio_en",   32'(bus.alu_enable), 32'd1);
      chk("prio_dest", 32'(bus.rs_fu_packet.dest_preg_idx), 32'(i));
      chk("prio_opa",  bus.rs_fu_packet.opa_value, 32'(100 + i));
    end
    step();
    chk("prio_en_off", 32'(bus.alu_enable), 32'd0);
    chk("prio_free",   32'(bus.rs_free_count), 32'd8);

    // Asynchronous reset while an op is being issued
    disp(ALU_XOR, 1'b1, 32'd11, 1'b1, 32'd22, 6'd50, 5'd1);
    step();
    disp(ALU_XOR, 1'b0, 32'd35, 1'b1, 32'd0, 6'd51, 5'd2);
    step();
    idle();
    chk("ar_en_pre",   32'(bus.alu_enable), 32'd1);
    chk("ar_dest_pre", 32'(bus.rs_fu_packet.dest_preg_idx), 32'd50);
    chk("ar_free_pre", 32'(bus.rs_free_count), 32'd7);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_en",   32'(bus.alu_enable), 32'd0);
    chk("ar_opa",  bus.rs_fu_packet.opa_value, 32'd0);
    chk("ar_free", 32'(bus.rs_free_count), 32'd8);
    chk("ar_full", 32'(bus.rs_full), 32'd0);
    #3;
    reset = 1'b0;
    step();
    chk("ar_en_post",   32'(bus.alu_enable), 32'd0);
    chk("ar_free_post", 32'(bus.rs_free_count), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
